// File: rtl/cali_err_gen.sv
// cali_err_gen: clips, averages and scales the DTC-normalised TDC phase error
// and sequences settle/adapt/lock-hold so the calibration LUTs only update on trustworthy error data.
//
// Ports:
//   CLK, NRST        clock, async active-low reset
//   CALI_START/STOP  level controls (STOP wins)
//   PHE, PHE_VLD     phase-error sample and its valid
//   SETTLE_CYC       cycles to wait in SETTLE
//   ACC_LEN_LOG2     log2 of samples averaged per dump
//   ERR_SHIFT        output scaling, ERR = avg * 2^-ERR_SHIFT
//   LOCK_THR         lock threshold on |avg|
//   EN, ERR          one-cycle update strobe and its error value
//   STATE, DONE      phase (0 idle,1 settle,2 calib,3 hold), hold flag
//   OOR_CNT          saturating count of clipped samples
module cali_err_gen #(
  parameter int  CNT_W    = 16,
  parameter int  LOCK_CNT = 8,
  parameter real PHE_CLIP = 0.5
) (
  input  logic             NRST,
  input  logic             CLK,
  input  logic             CALI_START,
  input  logic             CALI_STOP,
  input  real              PHE,
  input  logic             PHE_VLD,
  input  logic [CNT_W-1:0] SETTLE_CYC,
  input  logic [2:0]       ACC_LEN_LOG2,
  input  logic [3:0]       ERR_SHIFT,
  input  real              LOCK_THR,
  output logic             EN,
  output real              ERR,
  output logic [1:0]       STATE,
  output logic             DONE,
  output logic [CNT_W-1:0] OOR_CNT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CALIB  = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_CNT);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] settle_q;
  logic [CNT_W-1:0] oor_q;
  logic [7:0]       smp_q;
  logic [LW-1:0]    lock_q;
  logic [2:0]       n_q;
  logic [3:0]       sh_q;
  real              acc_q;
  logic             en_q;
  real              err_q;
  logic             done_q;

  real              phc;
  logic             clipped;
  real              sum;
  real              avg;
  real              avg_abs;
  logic             in_thr;
  logic             last;
  logic [7:0]       smp_top;
  logic [LW-1:0]    lock_nx;

  // 2^-k as an exact real (powers of two scale without rounding)
  function automatic real pow2n(input logic [3:0] k);
    real r;
    r = 1.0;
    for (int i = 0; i < 15; i++) begin
      if (i < int'(k)) r = r * 0.5;
    end
    return r;
  endfunction

  always_comb begin
    phc     = PHE;
    clipped = 1'b0;
    if (PHE > PHE_CLIP) begin
      phc     = PHE_CLIP;
      clipped = 1'b1;
    end else if (PHE < -PHE_CLIP) begin
      phc     = -PHE_CLIP;
      clipped = 1'b1;
    end
    sum     = acc_q + phc;
    smp_top = (8'd1 << n_q) - 8'd1;
    last    = (smp_q == smp_top);
    avg     = sum * pow2n({1'b0, n_q});
    avg_abs = (avg < 0.0) ? -avg : avg;
    in_thr  = (avg_abs < LOCK_THR);
    lock_nx = lock_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      oor_q    <= '0;
      smp_q    <= '0;
      lock_q   <= '0;
      n_q      <= '0;
      sh_q     <= '0;
      acc_q    <= 0.0;
      en_q     <= 1'b0;
      err_q    <= 0.0;
      done_q   <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      err_q <= 0.0;
      if (CALI_STOP) begin
        // any pending dump strobe is dropped by the defaults above
        state_q  <= S_IDLE;
        settle_q <= '0;
        smp_q    <= '0;
        lock_q   <= '0;
        acc_q    <= 0.0;
        done_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (CALI_START) begin
              state_q  <= S_SETTLE;
              settle_q <= '0;
              oor_q    <= '0;
            end
          end
          S_SETTLE: begin
            if (settle_q == SETTLE_CYC) begin
              state_q <= S_CALIB;
              n_q     <= ACC_LEN_LOG2;
              sh_q    <= ERR_SHIFT;
              acc_q   <= 0.0;
              smp_q   <= '0;
              lock_q  <= '0;
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end
          S_CALIB: begin
            if (PHE_VLD) begin
              if (clipped && (oor_q != '1)) oor_q <= oor_q + 1'b1;
              if (last) begin
                en_q  <= 1'b1;
                err_q <= avg * pow2n(sh_q);
                acc_q <= 0.0;
                smp_q <= '0;
                if (in_thr) begin
                  lock_q <= lock_nx;
                  if (lock_nx == LOCK_TOP) begin
                    state_q <= S_HOLD;
                    done_q  <= 1'b1;
                  end
                end else begin
                  lock_q <= '0;
                end
              end else begin
                acc_q <= sum;
                smp_q <= smp_q + 1'b1;
              end
            end
          end
          default: begin
            done_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign EN      = en_q;
  assign ERR     = err_q;
  assign STATE   = state_q;
  assign DONE    = done_q;
  assign OOR_CNT = oor_q;

endmodule

// File: tb/tb_cali_err_gen.sv
// tb_cali_err_gen: scoreboard bench for cali_err_gen.
// Expected strobes are queued with their due cycle when samples are driven.
module tb_cali_err_gen;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        CALI_START = 1'b0;
  logic        CALI_STOP = 1'b0;
  real         PHE = 0.0;
  logic        PHE_VLD = 1'b0;
  logic [15:0] SETTLE_CYC = 16'd4;
  logic [2:0]  ACC_LEN_LOG2 = 3'd0;
  logic [3:0]  ERR_SHIFT = 4'd0;
  real         LOCK_THR = 0.0;
  logic        EN;
  real         ERR;
  logic [1:0]  STATE;
  logic        DONE;
  logic [15:0] OOR_CNT;

  cali_err_gen dut (
    .NRST(NRST), .CLK(CLK),
    .CALI_START(CALI_START), .CALI_STOP(CALI_STOP),
    .PHE(PHE), .PHE_VLD(PHE_VLD),
    .SETTLE_CYC(SETTLE_CYC), .ACC_LEN_LOG2(ACC_LEN_LOG2),
    .ERR_SHIFT(ERR_SHIFT), .LOCK_THR(LOCK_THR),
    .EN(EN), .ERR(ERR), .STATE(STATE),
    .DONE(DONE), .OOR_CNT(OOR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    real err;
    int  cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  bit   mon_on = 1'b0;
  bit   m_on = 1'b0;
  real  m_acc = 0.0;
  int   m_cnt = 0;
  int   m_n = 0;
  int   m_sh = 0;
  int   ns;

  task automatic chk(string tag, real obs, real exp);
    total++;
    if ((obs - exp > 1e-9) || (exp - obs > 1e-9)) begin
      bad++;
      $display("FAIL %s: got %f want %f", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_on) begin
      if (EN) begin
        pulses++;
        if (q.size() == 0) begin
          chk("en_spur", 1.0, 0.0);
        end else begin
          chk("en_cyc", real'(cyc), real'(q[0].cyc));
          chk("err", ERR, q[0].err);
          q.delete(0);
        end
      end else begin
        chk("err_idle", ERR, 0.0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk("en_miss", 0.0, 1.0);
          q.delete(0);
        end
      end
    end
  end

  task automatic model(real v, bit vld);
    real  p;
    exp_t e;
    if (m_on && vld) begin
      p = (v > 0.5) ? 0.5 : ((v < -0.5) ? -0.5 : v);
      m_acc = m_acc + p;
      m_cnt++;
      if (m_cnt == (1 << m_n)) begin
        e.err = m_acc / real'(1 << m_n) / real'(1 << m_sh);
        e.cyc = cyc + 1;
        q.push_back(e);
        m_acc = 0.0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic drive(real v, bit vld);
    @(negedge CLK);
    PHE = v;
    PHE_VLD = vld;
    model(v, vld);
  endtask

  task automatic start(output int n_settle);
    bit hit;
    hit = 1'b0;
    n_settle = 0;
    @(negedge CLK);
    CALI_START = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge CLK);
      if (STATE == 2'd2) begin
        hit = 1'b1;
        CALI_START = 1'b0;
        m_on = 1'b1;
        m_n = int'(ACC_LEN_LOG2);
        m_sh = int'(ERR_SHIFT);
        m_acc = 0.0;
        m_cnt = 0;
        model(PHE, PHE_VLD);
      end else if (STATE == 2'd1) begin
        n_settle++;
      end
    end
    if (!hit) begin
      CALI_START = 1'b0;
      chk("calib_timeout", 0.0, 1.0);
    end
  endtask

  task automatic stop(real v, bit vld);
    @(negedge CLK);
    CALI_STOP = 1'b1;
    CALI_START = 1'b0;
    PHE = v;
    PHE_VLD = vld;
    m_on = 1'b0;
    @(negedge CLK);
    chk("stop_state", real'(STATE), 0.0);
    chk("stop_en", real'(EN), 0.0);
    chk("stop_done", real'(DONE), 0.0);
    CALI_STOP = 1'b0;
    PHE_VLD = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_state", real'(STATE), 0.0);
    chk("rst_en", real'(EN), 0.0);
    chk("rst_err", ERR, 0.0);
    chk("rst_done", real'(DONE), 0.0);
    chk("rst_oor", real'(OOR_CNT), 0.0);
    NRST = 1'b1;
    mon_on = 1'b1;

    // pass-through, settle length 5
    PHE = 0.1;
    PHE_VLD = 1'b1;
    pulses = 0;
    start(ns);
    chk("settle_len", real'(ns), 5.0);
    repeat (6) drive(0.1, 1'b1);
    drive(0.0, 1'b0);
    drive(0.0, 1'b0);
    chk("t1_pulses", real'(pulses), 7.0);
    chk("t1_q", real'(q.size()), 0.0);
    stop(0.0, 1'b0);

    // 4-sample average with valid gap, mid-run config change ignored
    SETTLE_CYC = 16'd0;
    ACC_LEN_LOG2 = 3'd2;
    ERR_SHIFT = 4'd1;
    pulses = 0;
    start(ns);
    chk("settle_zero", real'(ns), 1.0);
    ACC_LEN_LOG2 = 3'd0;
    ERR_SHIFT = 4'd0;
    drive(0.1, 1'b1);
    drive(0.2, 1'b1);
    drive(0.0, 1'b0);
    drive(0.0, 1'b0);
    drive(0.3, 1'b1);
    drive(0.4, 1'b1);
    repeat (3) drive(0.0, 1'b0);
    chk("t2_pulses", real'(pulses), 1.0);
    chk("t2_q", real'(q.size()), 0.0);
    stop(0.0, 1'b0);

    // clipping and out-of-range count
    pulses = 0;
    start(ns);
    drive(0.9, 1'b1);
    drive(-0.7, 1'b1);
    drive(0.0, 1'b0);
    drive(0.0, 1'b0);
    chk("oor_cnt", real'(OOR_CNT), 2.0);
    chk("t3_pulses", real'(pulses), 2.0);
    stop(0.0, 1'b0);
    chk("oor_keep", real'(OOR_CNT), 2.0);

    // lock after 8 good dumps
    LOCK_THR = 0.05;
    pulses = 0;
    start(ns);
    chk("oor_clr", real'(OOR_CNT), 0.0);
    repeat (8) drive(0.01, 1'b1);
    drive(0.0, 1'b0);
    drive(0.0, 1'b0);
    chk("lock_pulses", real'(pulses), 8.0);
    chk("hold_state", real'(STATE), 3.0);
    chk("hold_done", real'(DONE), 1.0);
    chk("hold_en", real'(EN), 0.0);
    CALI_START = 1'b1;
    drive(0.0, 1'b0);
    drive(0.0, 1'b0);
    CALI_START = 1'b0;
    chk("hold_start_ign", real'(STATE), 3.0);
    stop(0.0, 1'b0);

    // an out-of-threshold dump restarts the lock count
    pulses = 0;
    start(ns);
    repeat (4) drive(0.01, 1'b1);
    drive(0.2, 1'b1);
    repeat (8) drive(0.01, 1'b1);
    drive(0.0, 1'b0);
    drive(0.0, 1'b0);
    chk("relock_pulses", real'(pulses), 13.0);
    chk("relock_state", real'(STATE), 3.0);
    stop(0.0, 1'b0);

    // stop on the dump cycle, then a fresh restart
    LOCK_THR = 0.0;
    ACC_LEN_LOG2 = 3'd2;
    pulses = 0;
    start(ns);
    repeat (3) drive(0.1, 1'b1);
    stop(0.1, 1'b1);
    chk("stop_pulses", real'(pulses), 0.0);
    start(ns);
    repeat (3) drive(0.3, 1'b1);
    drive(0.0, 1'b0);
    chk("fresh_none", real'(pulses), 0.0);
    drive(0.3, 1'b1);
    drive(0.0, 1'b0);
    drive(0.0, 1'b0);
    chk("fresh_one", real'(pulses), 1.0);
    stop(0.0, 1'b0);

    // asynchronous reset mid-calibration
    ACC_LEN_LOG2 = 3'd1;
    pulses = 0;
    start(ns);
    drive(0.9, 1'b1);
    drive(0.9, 1'b1);
    drive(0.9, 1'b1);
    PHE_VLD = 1'b0;
    @(negedge CLK);
    #2;
    NRST = 1'b0;
    #1;
    chk("arst_state", real'(STATE), 0.0);
    chk("arst_en", real'(EN), 0.0);
    chk("arst_err", ERR, 0.0);
    chk("arst_done", real'(DONE), 0.0);
    chk("arst_oor", real'(OOR_CNT), 0.0);
    chk("pre_rst_pulse", real'(pulses), 1.0);
    m_on = 1'b0;
    @(negedge CLK);
    NRST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_idle", real'(STATE), 0.0);
    chk("post_rst_q", real'(q.size()), 0.0);
    CALI_START = 1'b1;
    @(negedge CLK);
    CALI_START = 1'b0;
    chk("post_rst_start", real'(STATE), 1.0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cali_err_gen.md
Name: cali_err_gen

Overview:
- Upstream error-conditioning stage for the piecewise DTC calibration (RLS/LMS LUT engine).
- Takes the raw TDC phase-error sample PHE, already normalized to DTC-gain units.
- Produces the ERR value and the EN update strobe the calibration engine consumes, from an averaged, clipped and scaled PHE.
- Sequences the calibration through settle, adapt and lock-hold phases, so the downstream LUTs only update on trustworthy error data.

Parameters:
- CNT_W, 16: width of the settle counter and the out-of-range counter.
- LOCK_CNT, 8: number of consecutive in-threshold dumps required to declare lock.
- PHE_CLIP, 0.5 (real): symmetric clip magnitude applied to PHE before accumulation.

Ports:
- NRST  input  1  asynchronous active-low reset
- CLK  input  1  clock; reset NRST, asynchronous, active-low; clock CLK
- CALI_START  input  1  level; starts calibration from IDLE
- CALI_STOP  input  1  level; forces return to IDLE
- PHE  input  real  phase-error sample
- PHE_VLD  input  1  PHE valid this cycle
- SETTLE_CYC  input  CNT_W  number of cycles to wait in SETTLE
- ACC_LEN_LOG2  input  3  accumulate 2^N valid samples per dump (0 = pass-through)
- ERR_SHIFT  input  4  output scaling, ERR = avg * 2^-ERR_SHIFT
- LOCK_THR  input  real  lock threshold on |avg|
- EN  output  1  one-cycle update strobe to the calibration engine
- ERR  output  real  error value, valid while EN=1, otherwise 0.0
- STATE  output  2  0 IDLE, 1 SETTLE, 2 CALIB, 3 HOLD
- DONE  output  1  high while in HOLD
- OOR_CNT  output  CNT_W  saturating count of clipped PHE samples

Behaviour:
- Reset values:
  - State IDLE; all outputs 0 / 0.0.
  - Internal accumulator, sample counter, settle counter and lock counter are 0.
- All outputs are registered; no combinational path from any input to any output.
- Clip:
  - phc = PHE limited to [-PHE_CLIP, +PHE_CLIP].
  - When a valid sample is clipped, OOR_CNT increments and saturates at 2^CNT_W-1.
  - OOR_CNT is cleared only by reset or by the IDLE->SETTLE transition.
- IDLE:
  - EN=0, ERR=0.0.
  - CALI_START=1 -> SETTLE; settle counter loads 0; OOR_CNT clears.
- SETTLE:
  - The counter increments every cycle, regardless of PHE_VLD.
  - When the counter equals SETTLE_CYC -> CALIB.
  - SETTLE_CYC=0 gives one cycle in SETTLE.
  - PHE is ignored and EN=0.
- CALIB:
  - Each cycle with PHE_VLD=1: acc += phc and the sample counter increments.
  - The cycle on which the 2^N-th valid sample is taken is the dump cycle:
    - avg = (acc + phc) * 2^-N.
    - On the next cycle EN=1 and ERR = avg * 2^-ERR_SHIFT, for exactly one cycle.
    - acc and the sample counter restart from 0 on that edge.
  - Latency is 1 cycle from the dump-sample edge to EN/ERR.
  - N=0: each valid sample gives EN=1 on the following cycle, ERR = phc * 2^-ERR_SHIFT.
  - A PHE_VLD gap stalls accumulation with no loss of the partial sum.
  - ACC_LEN_LOG2 and ERR_SHIFT are sampled only on entry to CALIB; changes mid-CALIB are ignored.
- Lock:
  - At each dump, |avg| < LOCK_THR increments the lock counter; otherwise the lock counter clears.
  - When the lock counter reaches LOCK_CNT -> HOLD. That final dump's EN/ERR strobe is still issued.
- HOLD:
  - EN=0, ERR=0.0, DONE=1.
  - Remains until CALI_STOP.
  - CALI_START is ignored.
- CALI_STOP=1 in any state:
  - Next state IDLE.
  - acc, sample, settle and lock counters clear.
  - EN and DONE go 0 on the next edge; any pending dump strobe is discarded.
- CALI_STOP and CALI_START both high: STOP wins, state stays or becomes IDLE.
- CALI_START in SETTLE, CALIB or HOLD: ignored.
- Reset mid-operation: immediate asynchronous return to reset values; no strobe is emitted.

Test Plan:
- Reset then CALI_START=1, SETTLE_CYC=4, ACC_LEN_LOG2=0, ERR_SHIFT=0, PHE=0.1 constant with PHE_VLD=1:
  - STATE reads 1 for 5 cycles, then 2.
  - EN=1 every cycle from the second cycle of CALIB, with ERR=0.1.
- ACC_LEN_LOG2=2, ERR_SHIFT=1, PHE sequence 0.1, 0.2, 0.3, 0.4 with a 2-cycle PHE_VLD=0 gap after the 2nd sample:
  - A single EN pulse, one cycle after the 4th sample, with ERR=0.125.
  - EN=0 on all other cycles.
- PHE=0.9 and -0.7 with PHE_CLIP=0.5, N=0:
  - ERR=0.5 then -0.5.
  - OOR_CNT=2.
- LOCK_THR=0.05, LOCK_CNT=8, N=0, PHE=0.01:
  - Exactly 8 EN pulses, then STATE=3 and DONE=1 with EN=0.
  - Inserting PHE=0.2 at the 5th sample restarts the count, giving 13 pulses total.
- CALI_STOP asserted on the dump cycle in CALIB:
  - No EN pulse is issued.
  - STATE=0 on the next cycle.
  - A restart produces its first dump only after a full fresh 2^N samples.
- NRST pulsed low mid-CALIB with a partial accumulation:
  - All outputs return to 0 asynchronously.
  - After release, STATE=0 until CALI_START.
